// File: rtl/crc_frame_pkg.sv
// Shared types and helpers for the CRC frame serializer.
package crc_frame_pkg;

  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT,
    APPEND
  } state_t;

  // Requested CRC msb limited to what the engine register can supply.
  function automatic int clamp_msb(input int msb, input int max_width);
    return (msb > max_width - 1) ? max_width - 1 : msb;
  endfunction

endpackage

// File: rtl/crc_word_shift.sv
// Word load/shift register with selectable bit order; last_bit flags the final bit of the word.
// Latency: load visible next cycle; shifts only when shift is high, so it holds under backpressure.
module crc_word_shift
  import crc_frame_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [DW-1:0] load_dat,
  input  logic          load_lsb_first,
  output logic          bit_dat,
  output logic          last_bit
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] sreg;
  logic [BW-1:0] bitcnt;
  logic          lsb_q;

  // A load wins over a shift so the next word can follow the last bit gaplessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= '0;
      bitcnt <= '0;
      lsb_q  <= 1'b0;
    end else if (load) begin
      sreg   <= load_dat;
      bitcnt <= BW'(DW - 1);
      lsb_q  <= load_lsb_first;
    end else if (shift) begin
      sreg   <= lsb_q ? (sreg >> 1) : (sreg << 1);
      bitcnt <= bitcnt - 1'b1;
    end
  end

  assign bit_dat  = lsb_q ? sreg[0] : sreg[DW-1];
  assign last_bit = (bitcnt == '0);

endmodule

// File: rtl/crc_frame_ser.sv
// Serializes words to bits, steps the CRC engine per data bit, then appends the CRC MSB-first.
// Latency 1 cycle from word accept to first bit; out_ready low freezes shifting and engine steps.
module crc_frame_ser
  import crc_frame_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int CW        = $clog2(MAX_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  input  logic                 lsb_first,
  input  logic [CW:0]          msb,
  input  logic                 crc_inv,
  input  logic [MAX_WIDTH-1:0] crc_sum,
  output logic                 crc_x,
  output logic                 crc_en,
  output logic                 crc_clr,
  output logic                 out_valid,
  output logic                 out_bit,
  input  logic                 out_ready,
  output logic                 frame_done
);

  state_t        state;
  logic          last_q;
  logic          inv_q;
  logic          clr_q;
  logic [CW-1:0] msb_q;
  logic [CW-1:0] acnt;

  logic sh_bit;
  logic sh_last;
  logic data_step;
  logic data_end;
  logic load;

  assign data_step = (state == DATA) && out_ready;
  assign data_end  = data_step && sh_last;
  assign in_ready  = (state == IDLE) || (state == WAIT) || (data_end && !last_q);
  assign load      = in_valid && in_ready;

  assign out_valid  = (state == DATA) || (state == APPEND);
  assign out_bit    = (state == APPEND) ? (crc_sum[acnt] ^ inv_q) : sh_bit;
  assign crc_x      = sh_bit;
  // Masked during reset so a reload request never coincides with an engine step.
  assign crc_en     = data_step && !rst;
  assign frame_done = (state == APPEND) && out_ready && (acnt == '0);
  assign crc_clr    = rst || clr_q;

  crc_word_shift #(.DW(DW)) u_shift (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .shift         (data_step),
    .load_dat      (in_data),
    .load_lsb_first(lsb_first),
    .bit_dat       (sh_bit),
    .last_bit      (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_q <= 1'b0;
      inv_q  <= 1'b0;
      msb_q  <= '0;
      acnt   <= '0;
      clr_q  <= 1'b1;
    end else begin
      clr_q <= frame_done;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= DATA;
            last_q <= in_last;
            msb_q  <= CW'(clamp_msb(int'(msb), MAX_WIDTH));
            inv_q  <= crc_inv;
          end
        end
        WAIT: begin
          if (in_valid) begin
            state  <= DATA;
            last_q <= in_last;
          end
        end
        DATA: begin
          if (data_end) begin
            if (last_q) begin
              state <= APPEND;
              acnt  <= msb_q;
            end else if (in_valid) begin
              last_q <= in_last;
            end else begin
              state <= WAIT;
            end
          end
        end
        APPEND: begin
          if (out_ready) begin
            if (acnt == '0) state <= IDLE;
            else            acnt  <= acnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_frame_ser.md
Name: crc_frame_ser

Overview:
Frame serializer that sits directly upstream of the bit-serial CRC engine. It accepts DW-bit words over a valid/ready handshake and emits them as a bit stream with its own valid/ready handshake. For every data bit accepted downstream, it drives one CRC-engine step (crc_x, crc_en). After the last word of a frame, it appends the engine's CRC value (msb+1 bits, MSB-first) to the bit stream, then pulses crc_clr so the engine reloads its initial value for the next frame.

Parameters:
DW, 8, input word width in bits
MAX_WIDTH, 32, maximum CRC width; must equal the engine's MAX_WIDTH
CW, $clog2(MAX_WIDTH), width of the msb field minus 1 (msb is CW+1 bits)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  DW  input word
in_last  in  1  word is the last of its frame
lsb_first  in  1  bit order of in_data, sampled with each accepted word
msb  in  CW+1  active CRC width-1, sampled with the first word of a frame
crc_inv  in  1  invert appended CRC bits, sampled with the first word of a frame
crc_sum  in  MAX_WIDTH  CRC engine register value
crc_x  out  1  serial bit to CRC engine
crc_en  out  1  CRC engine step enable (engine setb; halt tied low)
crc_clr  out  1  engine reload request (engine holds its initial value while high)
out_valid  out  1  serial bit valid
out_bit  out  1  serial bit
out_ready  in  1  downstream accepts bit when out_valid & out_ready
frame_done  out  1  one-cycle pulse when the final CRC bit is accepted

Behaviour:
- States: IDLE (no frame), DATA (shifting a word), WAIT (mid-frame, no word held), APPEND (shifting CRC).
- Reset: state=IDLE. in_ready=1 follows from IDLE. out_valid=0, crc_en=0, frame_done=0. crc_clr=1 while rst is high and for the first cycle after rst falls. Shift register, bit counter and captured config are all cleared. Reset mid-frame aborts the frame with no further output bits.
- in_ready: combinational.
  - 1 in IDLE and WAIT.
  - 1 in DATA only when the last bit of the current word is accepted this cycle and the current word is not last. This allows gapless word-to-word streaming.
  - 0 in APPEND.
- Accept in IDLE: load word, bitcnt=DW-1, capture lsb_first, in_last, msb (clamped to MAX_WIDTH-1 if larger), crc_inv. Next state DATA. First out_valid appears the next cycle (latency 1).
- DATA:
  - out_valid=1. out_bit = in_data bit 0 upward if lsb_first, else bit DW-1 downward.
  - crc_x = out_bit. crc_en = out_valid & out_ready, combinational, exactly one step per accepted bit.
  - out_ready low stalls: shift register, counter and crc_en hold.
- Last bit of a word accepted:
  - If the word is last: go to APPEND, acnt = captured msb.
  - Else if in_valid: load the next word (its lsb_first is re-sampled), stay in DATA.
  - Else: go to WAIT with out_valid=0.
- WAIT: in_ready=1. Accepting a word goes to DATA with the same rules as IDLE, but msb and crc_inv are not re-sampled.
- APPEND:
  - out_valid=1, crc_en=0.
  - out_bit = crc_sum[acnt] ^ crc_inv. The engine is frozen, so crc_sum holds the final value; it is read live and no snapshot is taken.
  - acnt decrements per accepted bit.
  - On accepting the bit at acnt==0: frame_done=1 that cycle, crc_clr=1 the next cycle (registered), next state IDLE.
- msb=0: exactly one CRC bit is appended.
- in_last on the first word with DW bits: frame length is DW + msb + 1 output bits.
- crc_clr is never high in the same cycle as crc_en.
- No output depends combinationally on in_valid except in_ready (no valid-from-ready loops).

Decomposition:
- Package crc_frame_pkg: state enum (IDLE, DATA, WAIT, APPEND), default DW and MAX_WIDTH constants, and function clamp_msb.
- One natural sub-module, crc_word_shift: DW-bit load/shift register with bit-order select and down-counter, reporting last_bit. The FSM stays in the top level.

Test Plan:
- Reset then DW=8, msb=7, crc_inv=0, single word 0xA5, lsb_first=0, out_ready=1 → out bits 1,0,1,0,0,1,0,1, with crc_en high on exactly those 8 cycles and crc_x equal to out_bit. Then 8 bits equal to crc_sum[7:0] MSB-first, frame_done on the 16th accepted bit, crc_clr on the next cycle.
- Words 0x01 then 0x80 (last) with lsb_first=1, in_valid held high → 16 data bits with no out_valid gap; bits are 1,0×7,0×7,1; in_ready pulses on the 8th bit accept.
- Random out_ready (about 50% duty) on a 3-word frame → bit sequence identical to the out_ready=1 run; number of crc_en pulses = 24.
- in_valid dropped for 5 cycles between words → state WAIT; out_valid=0 and crc_en=0 for those cycles; resumes on the next word without re-sampling msb.
- msb=0, crc_inv=1 → exactly one appended bit equal to ~crc_sum[0]. msb=40 with MAX_WIDTH=32 → 32 appended bits.
- rst asserted during APPEND at acnt=3 → next cycle out_valid=0, in_ready=1, crc_clr=1; frame_done never pulses.
